// File: rtl/video_sync_gen.sv
// video_sync_gen: programmable video timing master.
// Produces a one-clk pixel enable every CE_DIV clocks. On each enable it
// presents registered sync, blanking, data-enable and counter outputs for
// the current pixel. Interlace mode is optional: odd fields are one line
// longer, and their VSync edges fall at mid-line (hc = H_TOTAL/2).
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   interlace  interlace request, sampled only at a field boundary
//   ce_pix     one-clk pixel enable pulse
//   HSync      horizontal sync, level per HS_POL
//   VSync      vertical sync, level per VS_POL
//   HBlank     high outside active pixels
//   VBlank     high outside active lines
//   de         high for active pixels on active lines
//   h_cnt      pixel index of the presented pixel
//   v_cnt      line index of the presented pixel within its field
//   field      0 = even/progressive field, 1 = odd field
module video_sync_gen #(
  parameter int CE_DIV   = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interlace,
  output logic        ce_pix,
  output logic        HSync,
  output logic        VSync,
  output logic        HBlank,
  output logic        VBlank,
  output logic        de,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        field
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_HALF   = 11'(H_TOTAL / 2);
  localparam logic [10:0] V_LAST_E = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_LAST_O = 11'(V_TOTAL);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [10:0]      hc;
  logic [10:0]      vc;
  logic             fld;
  logic             il;

  logic        tick;
  logic        odd_il;
  logic        h_last;
  logic        v_last;
  logic        hs_act;
  logic        vs_act;
  logic [10:0] vs_edge;

  always_comb begin
    tick    = (div == DIV_LAST);
    odd_il  = fld & il;
    h_last  = (hc == H_LAST);
    v_last  = (vc == (odd_il ? V_LAST_O : V_LAST_E));
    hs_act  = (hc >= HS_START) && (hc < HS_END);
    // The VSync window is bounded by (line, column) positions. The column
    // is 0 normally and mid-line on interlaced odd fields.
    vs_edge = odd_il ? H_HALF : '0;
    vs_act  = ((vc == VS_START) && (hc >= vs_edge)) ||
              ((vc >  VS_START) && (vc <  VS_END))  ||
              ((vc == VS_END)   && (hc <  vs_edge));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      hc     <= '0;
      vc     <= '0;
      fld    <= 1'b0;
      il     <= 1'b0;
      ce_pix <= 1'b0;
      HSync  <= ~HS_POL;
      VSync  <= ~VS_POL;
      HBlank <= 1'b1;
      VBlank <= 1'b1;
      de     <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
      field  <= 1'b0;
    end else begin
      ce_pix <= tick;
      div    <= tick ? '0 : div + 1'b1;
      if (tick) begin
        HBlank <= (hc >= H_ACT);
        VBlank <= (vc >= V_ACT);
        de     <= (hc < H_ACT) && (vc < V_ACT);
        HSync  <= hs_act ? HS_POL : ~HS_POL;
        VSync  <= vs_act ? VS_POL : ~VS_POL;
        h_cnt  <= hc;
        v_cnt  <= vc;
        field  <= fld;
        if (h_last) begin
          hc <= '0;
          if (v_last) begin
            vc  <= '0;
            // The field toggle uses the interlace mode of the field that is
            // ending; the request takes effect for the field that follows.
            fld <= il ? ~fld : 1'b0;
            il  <= interlace;
          end else begin
            vc <= vc + 1'b1;
          end
        end else begin
          hc <= hc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_sync_gen.sv
// Testbench for video_sync_gen. Two small-timing configurations run side by
// side: one with CE_DIV=4 and active-low syncs, and one with CE_DIV=1,
// active-high syncs and an odd line length. A reference model walks a linear
// pixel index through each field and pushes the expected pixel into a queue
// on every expected tick. A monitor pops the queue whenever ce_pix is seen.
module tb_video_sync_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        fld;
    logic        hb;
    logic        vb;
    logic        de;
    logic        hs;
    logic        vs;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int CE    = (g == 0) ? 4 : 1;
    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HSW   = 3;
    localparam int HBP   = (g == 0) ? 3 : 4;
    localparam int VA    = 6;
    localparam int VFP   = 2;
    localparam int VSW   = 2;
    localparam int VBP   = 2;
    localparam bit HP    = (g == 0) ? 1'b0 : 1'b1;
    localparam bit VP    = (g == 0) ? 1'b0 : 1'b1;
    localparam int HT    = HA + HFP + HSW + HBP;
    localparam int VT    = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT * CE;

    logic        rst;
    logic        il_in;
    logic        ce_pix, hs, vs, hb, vb, de, fld;
    logic [10:0] hcnt, vcnt;
    logic        done;

    pix_t        q[$];
    bit          rst_seen;
    int unsigned nclk, p, lines, off;
    bit          m_fld, m_il;
    pix_t        e, act, exp_v;

    video_sync_gen #(
      .CE_DIV(CE), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(HP), .VS_POL(VP)
    ) dut (
      .clk(clk), .reset(rst), .interlace(il_in), .ce_pix(ce_pix),
      .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb), .de(de),
      .h_cnt(hcnt), .v_cnt(vcnt), .field(fld)
    );

    // Reference model: a tick every CE clocks after reset; the pixel position
    // is a linear index into the field.
    always @(posedge clk) begin
      if (rst) begin
        nclk = 0; p = 0; m_fld = 1'b0; m_il = 1'b0;
        q.delete();
        rst_seen = 1'b1;
      end else begin
        rst_seen = 1'b0;
        if (nclk % CE == CE - 1) begin
          lines = (m_fld && m_il) ? VT + 1 : VT;
          off   = (m_fld && m_il) ? HT / 2 : 0;
          e.h   = 11'(p % HT);
          e.v   = 11'(p / HT);
          e.fld = m_fld;
          e.hb  = (p % HT) >= HA;
          e.vb  = (p / HT) >= VA;
          e.de  = !e.hb && !e.vb;
          e.hs  = ((p % HT) >= HA + HFP && (p % HT) < HA + HFP + HSW) ? HP : !HP;
          e.vs  = (p >= (VA + VFP) * HT + off && p < (VA + VFP + VSW) * HT + off) ? VP : !VP;
          q.push_back(e);
          p++;
          if (p == lines * HT) begin
            p     = 0;
            m_fld = m_il ? !m_fld : 1'b0;
            m_il  = il_in;
          end
        end
        nclk++;
      end
    end

    // Monitor: sample outputs away from the active edge.
    always @(negedge clk) begin
      act = {hcnt, vcnt, fld, hb, vb, de, hs, vs};
      if (rst_seen) begin
        n_checks++;
        exp_v = {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, !HP, !VP};
        if (ce_pix !== 1'b0 || act !== exp_v) begin
          n_fail++;
          $display("FAIL cfg%0d reset_state: got ce=%0b bits=%h, expected ce=0 bits=%h",
                   g, ce_pix, act, exp_v);
        end
      end else if (ce_pix === 1'b1) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL cfg%0d unexpected_ce: ce_pix=1 at t=%0t, expected 0", g, $time);
        end else begin
          exp_v = q.pop_front();
          if (act !== exp_v) begin
            n_fail++;
            $display("FAIL cfg%0d pixel: got h=%0d v=%0d f=%0b hb=%0b vb=%0b de=%0b hs=%0b vs=%0b, expected h=%0d v=%0d f=%0b hb=%0b vb=%0b de=%0b hs=%0b vs=%0b",
                     g, act.h, act.v, act.fld, act.hb, act.vb, act.de, act.hs, act.vs,
                     exp_v.h, exp_v.v, exp_v.fld, exp_v.hb, exp_v.vb, exp_v.de, exp_v.hs, exp_v.vs);
          end
        end
      end else if (q.size() != 0) begin
        n_checks++;
        n_fail++;
        exp_v = q.pop_front();
        $display("FAIL cfg%0d missing_ce: ce_pix=%0b at t=%0t, expected 1 for h=%0d v=%0d",
                 g, ce_pix, $time, exp_v.h, exp_v.v);
      end
    end

    // Bounded wait for a DUT position. kind 0: v_cnt==a; kind 1: odd field
    // and v_cnt==a; kind 2: h_cnt==a and v_cnt==b. Always on a ce_pix.
    task automatic wait_pos(input int kind, input int a, input int b, input int limit);
      bit ok = 1'b0;
      for (int k = 0; k < limit; k++) begin
        @(negedge clk);
        if (ce_pix === 1'b1 &&
            ((kind == 0 && vcnt == 11'(a)) ||
             (kind == 1 && fld === 1'b1 && vcnt == 11'(a)) ||
             (kind == 2 && hcnt == 11'(a) && vcnt == 11'(b)))) begin
          ok = 1'b1;
          break;
        end
      end
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL cfg%0d wait_timeout: kind=%0d a=%0d b=%0d not reached in %0d clks",
                 g, kind, a, b, limit);
      end
    endtask

    initial begin
      int hr, vr;
      done  = 1'b0;
      rst   = 1'b1;
      il_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      // Progressive fields.
      repeat (2 * FRAME) @(negedge clk);
      // Raise interlace mid-field; it only takes effect at a field boundary.
      wait_pos(0, VA / 2, 0, 2 * FRAME);
      il_in = 1'b1;
      repeat (6 * FRAME) @(negedge clk);
      // Drop interlace during an odd field; that field keeps its extra line.
      wait_pos(1, 2, 0, 4 * FRAME);
      il_in = 1'b0;
      repeat (3 * FRAME) @(negedge clk);
      // Random interlace changes at arbitrary points.
      repeat (6) begin
        repeat ($urandom_range(1, FRAME)) @(negedge clk);
        il_in = 1'($urandom_range(0, 1));
      end
      repeat (2 * FRAME) @(negedge clk);
      // Mid-frame reset at a random active position.
      hr = $urandom_range(1, HT - 1);
      vr = $urandom_range(1, VT - 2);
      wait_pos(2, hr, vr, 3 * FRAME);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst   = 1'b0;
      il_in = 1'b0;
      repeat (2 * FRAME) @(negedge clk);
      done = 1'b1;
    end
  end

  initial begin
    bit ok = 1'b0;
    for (int k = 0; k < 90000; k++) begin
      @(posedge clk);
      if (cfg[0].done === 1'b1 && cfg[1].done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL run_timeout: done=%0b%0b, expected 11", cfg[1].done, cfg[0].done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_sync_gen.md
Name: video_sync_gen

Overview:
Programmable video timing generator: the transmitting end of the HSync/VSync/ce_pix pixel-timing interface that overlay and scaler consumers lock onto. Produces the pixel clock enable, sync pulses with selectable polarity, blanking, data-enable and pixel/line counters. Supports optional interlace, where odd fields are one line longer and VSync edges are shifted by half a line. Used as the timing master for test patterns and for the loader/OSD screen when no core video is active.

Parameters:
CE_DIV, 4, clk cycles per pixel (1..16)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, HSync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per field
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, VSync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, 1 = HSync active high, 0 = active low
VS_POL, 0, 1 = VSync active high, 0 = active low

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
interlace  in  1  interlace request; sampled only at field boundary
ce_pix  out  1  one-clk pixel enable pulse
HSync  out  1  horizontal sync, polarity per HS_POL
VSync  out  1  vertical sync, polarity per VS_POL
HBlank  out  1  high outside active pixels
VBlank  out  1  high outside active lines
de  out  1  ~HBlank & ~VBlank
h_cnt  out  11  pixel index of current output pixel
v_cnt  out  11  line index within current field
field  out  1  0 = even/progressive field, 1 = odd field

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; both must be < 2048; 11-bit unsigned arithmetic.
- Divider div counts 0..CE_DIV-1. A tick occurs when div==CE_DIV-1. On the tick edge, ce_pix<=1; otherwise ce_pix<=0. With CE_DIV=1, ce_pix stays high from the first edge after reset.
- On each tick, all other outputs are registered from the decode of internal counters (hc, vc), then the counters advance. Outputs are therefore valid and mutually consistent in the clk where ce_pix=1.
- Counter advance: hc wraps at H_TOTAL-1 to 0, and vc increments on the wrap. vc wraps to 0 at the field's last line: V_TOTAL-1 if the field is even or il=0, V_TOTAL if the field is odd and il=1.
- At vc wrap: if il=1, field toggles, else field<=0. The internal il is re-sampled from interlace at every vc wrap. A mid-field change of interlace has no effect until the next wrap.
- Decode:
  - HBlank = hc>=H_ACTIVE.
  - VBlank = vc>=V_ACTIVE.
  - HSync active for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
- VSync, even field: active from (vc=V_ACTIVE+V_FP, hc=0) up to, not including, (vc=V_ACTIVE+V_FP+V_SYNC, hc=0).
- VSync, odd field with il=1: same start/end lines, but both edges occur at hc=H_TOTAL/2 (integer division) instead of hc=0.
- Output level of each sync = active ? POL : ~POL.
- h_cnt/v_cnt/field outputs = hc/vc/field of the registered pixel.
- Reset (any time, including mid-frame): div=0, hc=0, vc=0, field=0, il=0, ce_pix=0, HSync=~HS_POL, VSync=~VS_POL, HBlank=1, VBlank=1, de=0, h_cnt=0, v_cnt=0.
- After reset: the first tick is on the CE_DIV-th rising edge after the reset-low edge, and presents pixel (0,0) with de=1.
- No other state; no handshakes. Consumers only sample on ce_pix.

Test Plan:
- Reset then run defaults, CE_DIV=4 -> first ce_pix 4 clks after reset release with h_cnt=0, v_cnt=0, de=1; ce_pix period exactly 4 clks thereafter.
- Defaults, progressive -> 800 ce_pix per line, 525 lines per field; HSync low for h_cnt 656..751 (96 pixels); VSync low on lines 490..491 starting at h_cnt=0; de high for 640x480 pixels per field; field stays 0.
- HS_POL=1, VS_POL=1 -> sync idle low and pulses high at identical positions; reset value of HSync/VSync = 0.
- interlace=1 before a field boundary -> fields alternate 525/526 lines; odd field VSync asserts at v_cnt=490, h_cnt=400 and deasserts at v_cnt=492, h_cnt=400; field output toggles at each wrap.
- interlace raised mid-field (v_cnt=100) -> current field unchanged at 525 lines; interlaced behaviour begins at the next field. Lowering it during an odd field -> that field still 526 lines, then field=0.
- Reset asserted at h_cnt=300, v_cnt=200, with CE_DIV=1 -> next edge shows all reset values; after release ce_pix is high on the first edge with pixel (0,0); the line-0 HSync pulse then starts at h_cnt=656.
